// File: rtl/counter_pkg.sv
// ----------------------------------------------------------------------------
// counter_pkg : shared defaults and boundary-mode type for mod_counter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package counter_pkg;

  localparam int CNT_WIDTH_DEF    = 6;
  localparam int CNT_PRESCALE_DEF = 1;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  // Decode the raw sat input into the boundary-mode type.
  function automatic cnt_mode_e cnt_mode_decode(input logic i_sat);
    return i_sat ? CNT_SAT : CNT_WRAP;
  endfunction

endpackage

`default_nettype wire

// File: rtl/count_prescaler.sv
// ----------------------------------------------------------------------------
// count_prescaler : divides en by PRESCALE, emitting a one-cycle out_tick
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module count_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = CNT_PRESCALE_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic sclr,
  input  logic en,
  output logic out_tick
);

  localparam int              c_PW   = $clog2(PRESCALE) + 1;
  localparam logic [c_PW-1:0] c_LAST = c_PW'(PRESCALE - 1);

  logic [c_PW-1:0] r_div;
  logic            w_last;

  assign w_last   = (r_div == c_LAST);
  assign out_tick = en && w_last;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_div <= '0;
    end else if (sclr) begin
      r_div <= '0;
    end else if (en) begin
      r_div <= w_last ? '0 : r_div + c_PW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mod_counter.sv
// ----------------------------------------------------------------------------
// mod_counter : up/down counter, programmable limit, load, wrap/saturate, tc.
// Optional enable prescaler compiled in with COUNTER_PRESCALE_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = CNT_WIDTH_DEF,
  parameter int PRESCALE = CNT_PRESCALE_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sclr,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  generate
    if (WIDTH < 1 || PRESCALE < 1) begin : g_param_check
      $error("mod_counter: WIDTH and PRESCALE must both be >= 1");
    end
  endgenerate

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             w_step;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_at_bnd;
  logic             w_at_up;
  logic             w_at_dn;
  cnt_mode_e        w_mode;

`ifdef COUNTER_PRESCALE_EN
  // Load restarts division as well as sclr.
  count_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .clr      (clr),
    .sclr     (sclr | load),
    .en       (en),
    .out_tick (w_step)
  );
`else
  assign w_step = en;
`endif

  assign w_mode   = cnt_mode_decode(sat);
  assign w_at_up  = (r_count >= limit);
  assign w_at_dn  = (r_count == '0);
  assign w_at_bnd = up ? w_at_up : w_at_dn;

  always_comb begin
    w_count_nxt = r_count;
    if (up) begin
      if (!w_at_up)                w_count_nxt = r_count + WIDTH'(1);
      else if (w_mode == CNT_WRAP) w_count_nxt = '0;
    end else begin
      if (!w_at_dn)                w_count_nxt = r_count - WIDTH'(1);
      else if (w_mode == CNT_WRAP) w_count_nxt = limit;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else if (sclr) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else if (load) begin
      r_count <= load_val;
      r_tc    <= 1'b0;
    end else if (w_step) begin
      r_count <= w_count_nxt;
      r_tc    <= w_at_bnd;
    end else begin
      r_tc    <= 1'b0;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;

endmodule

`default_nettype wire
